// File: rtl/clock_mode_ctrl_pkg.sv
// Shared types and constants for the clock/alarm mode controller.
// Field indices follow the order the left/right buttons step through.
package clock_mode_ctrl_pkg;

    localparam int unsigned H_W = 5;
    localparam int unsigned M_W = 6;

    typedef enum logic {
        MODE_CLOCK  = 1'b0,
        MODE_ADJUST = 1'b1
    } mode_e;

    typedef logic [1:0] field_t;

    localparam field_t F_CLK_H = 2'd0;
    localparam field_t F_CLK_M = 2'd1;
    localparam field_t F_ALM_H = 2'd2;
    localparam field_t F_ALM_M = 2'd3;

    function automatic logic [3:0] field_onehot(input field_t f);
        return 4'b0001 << f;
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Button/tick inputs and display/buzzer outputs of the clock mode controller.
// master = button conditioning side, slave = controller.
interface clock_mode_ctrl_if;
    import clock_mode_ctrl_pkg::*;

    logic           en_1hz;
    logic           btn_c;
    logic           btn_u;
    logic           btn_d;
    logic           btn_l;
    logic           btn_r;
    logic [H_W-1:0] hours;
    logic [M_W-1:0] minutes;
    logic [M_W-1:0] seconds;
    logic [H_W-1:0] alm_hours;
    logic [M_W-1:0] alm_minutes;
    logic           adjust_mode;
    logic [3:0]     sel_led;
    logic           alarm;

    modport master (
        output en_1hz, btn_c, btn_u, btn_d, btn_l, btn_r,
        input  hours, minutes, seconds, alm_hours, alm_minutes,
        input  adjust_mode, sel_led, alarm
    );

    modport slave (
        input  en_1hz, btn_c, btn_u, btn_d, btn_l, btn_r,
        output hours, minutes, seconds, alm_hours, alm_minutes,
        output adjust_mode, sel_led, alarm
    );

endinterface

// File: rtl/clock_mode_ctrl_wrap_counter.sv
// Modulo-MOD up/down counter with synchronous clear; carry flags an inc wrap.
// Priority: clr > (inc and dec together = hold) > inc/dec.
module wrap_counter #(
    parameter int unsigned MOD = 60,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] MAX = W'(MOD - 1);

    logic [W-1:0] r_value;
    logic [W-1:0] w_next;
    logic         w_up;
    logic         w_dn;

    assign w_up  = inc & ~dec & ~clr;
    assign w_dn  = dec & ~inc & ~clr;
    assign carry = w_up & (r_value == MAX);
    assign value = r_value;

    // Boundary compared before loading, so values above MAX never appear.
    always_comb begin
        w_next = r_value;
        if (clr) begin
            w_next = '0;
        end else if (w_up) begin
            w_next = (r_value == MAX) ? '0 : r_value + 1'b1;
        end else if (w_dn) begin
            w_next = (r_value == '0) ? MAX : r_value - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else begin
            r_value <= w_next;
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Time-of-day clock with alarm: CLOCK/ADJUST mode FSM, field select,
// button priority resolution and latched alarm flag.
module clock_mode_ctrl
    import clock_mode_ctrl_pkg::*;
#(
    parameter int unsigned H_MOD = 24,
    parameter int unsigned M_MOD = 60
) (
    input  logic               clk,
    input  logic               rst,
    clock_mode_ctrl_if.slave   bus
);

    mode_e          r_mode;
    mode_e          w_mode_next;
    field_t         r_sel;
    field_t         w_sel_next;
    logic [3:0]     r_sel_led;
    logic [3:0]     w_sel_led_next;
    logic           r_alarm;
    logic           w_alarm_next;

    logic           w_any_btn;
    logic           w_ev_clr;
    logic           w_ev_c;
    logic           w_ev_ud;
    logic           w_ev_lr;
    logic           w_run;
    logic           w_adj;
    logic           w_up;
    logic           w_dn;
    logic           w_hit;

    logic [H_W-1:0] w_hours;
    logic [M_W-1:0] w_minutes;
    logic [M_W-1:0] w_seconds;
    logic [H_W-1:0] w_alm_hours;
    logic [M_W-1:0] w_alm_minutes;
    logic           w_sec_carry;
    logic           w_min_carry;
    logic           w_hr_carry;
    logic [1:0]     w_unused_carry;
    logic [H_W-1:0] w_post_h;
    logic [M_W-1:0] w_post_m;

    // One event per cycle: alarm-clear swallows any tick, then centre,
    // then up/down, then left/right.
    assign w_any_btn = bus.btn_c | bus.btn_u | bus.btn_d | bus.btn_l | bus.btn_r;
    assign w_ev_clr  = r_alarm & w_any_btn;
    assign w_ev_c    = ~w_ev_clr & bus.btn_c;
    assign w_ev_ud   = ~w_ev_clr & ~bus.btn_c & (bus.btn_u | bus.btn_d);
    assign w_ev_lr   = ~w_ev_clr & ~bus.btn_c & ~(bus.btn_u | bus.btn_d)
                       & (bus.btn_l | bus.btn_r);

    assign w_run = (r_mode == MODE_CLOCK);
    assign w_adj = (r_mode == MODE_ADJUST);
    assign w_up  = w_adj & w_ev_ud & bus.btn_u & ~bus.btn_d;
    assign w_dn  = w_adj & w_ev_ud & bus.btn_d & ~bus.btn_u;

    wrap_counter #(.MOD(M_MOD), .W(M_W)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_run & bus.en_1hz),
        .dec   (1'b0),
        .clr   (w_run & w_ev_c),
        .value (w_seconds),
        .carry (w_sec_carry)
    );

    wrap_counter #(.MOD(M_MOD), .W(M_W)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   ((w_run & w_sec_carry) | (w_up & (r_sel == F_CLK_M))),
        .dec   (w_dn & (r_sel == F_CLK_M)),
        .clr   (1'b0),
        .value (w_minutes),
        .carry (w_min_carry)
    );

    // Minute carry only propagates while running, so edits never ripple.
    wrap_counter #(.MOD(H_MOD), .W(H_W)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .inc   ((w_run & w_min_carry) | (w_up & (r_sel == F_CLK_H))),
        .dec   (w_dn & (r_sel == F_CLK_H)),
        .clr   (1'b0),
        .value (w_hours),
        .carry (w_hr_carry)
    );

    wrap_counter #(.MOD(H_MOD), .W(H_W)) u_alm_hour (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_up & (r_sel == F_ALM_H)),
        .dec   (w_dn & (r_sel == F_ALM_H)),
        .clr   (1'b0),
        .value (w_alm_hours),
        .carry (w_unused_carry[0])
    );

    wrap_counter #(.MOD(M_MOD), .W(M_W)) u_alm_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_up & (r_sel == F_ALM_M)),
        .dec   (w_dn & (r_sel == F_ALM_M)),
        .clr   (1'b0),
        .value (w_alm_minutes),
        .carry (w_unused_carry[1])
    );

    // Match is taken on the time the counters will hold after this tick;
    // seconds==0 afterwards is exactly a seconds carry.
    assign w_post_m = w_min_carry ? '0 : w_minutes + 1'b1;
    assign w_post_h = w_min_carry ? (w_hr_carry ? '0 : w_hours + 1'b1) : w_hours;
    assign w_hit    = w_run & w_sec_carry
                      & (w_post_h == w_alm_hours) & (w_post_m == w_alm_minutes);

    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            MODE_CLOCK:  if (w_ev_c) w_mode_next = MODE_ADJUST;
            MODE_ADJUST: if (w_ev_c) w_mode_next = MODE_CLOCK;
        endcase
    end

    always_comb begin
        w_sel_next = r_sel;
        if (w_adj & w_ev_lr) begin
            if (bus.btn_r & ~bus.btn_l) begin
                w_sel_next = r_sel + 2'd1;
            end else if (bus.btn_l & ~bus.btn_r) begin
                w_sel_next = r_sel - 2'd1;
            end
        end
        w_sel_led_next = (w_mode_next == MODE_ADJUST) ? field_onehot(w_sel_next) : '0;
    end

    always_comb begin
        w_alarm_next = r_alarm;
        if (w_ev_clr) begin
            w_alarm_next = 1'b0;
        end else if (w_hit) begin
            w_alarm_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= MODE_CLOCK;
            r_sel     <= F_CLK_H;
            r_sel_led <= '0;
            r_alarm   <= 1'b0;
        end else begin
            r_mode    <= w_mode_next;
            r_sel     <= w_sel_next;
            r_sel_led <= w_sel_led_next;
            r_alarm   <= w_alarm_next;
        end
    end

    assign bus.hours       = w_hours;
    assign bus.minutes     = w_minutes;
    assign bus.seconds     = w_seconds;
    assign bus.alm_hours   = w_alm_hours;
    assign bus.alm_minutes = w_alm_minutes;
    assign bus.adjust_mode = (r_mode == MODE_ADJUST);
    assign bus.sel_led     = r_sel_led;
    assign bus.alarm       = r_alarm;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scenario bench for clock_mode_ctrl: expected output snapshots are queued
// with the stimulus and compared after the clock edge that should produce them.
module tb_clock_mode_ctrl;

    typedef struct {
        string       name;
        logic [33:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl #(.H_MOD(24), .M_MOD(60)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] obs();
        return {bus.hours, bus.minutes, bus.seconds, bus.alm_hours,
                bus.alm_minutes, bus.adjust_mode, bus.sel_led, bus.alarm};
    endfunction

    function automatic exp_t mk(input string n, input int h, input int m, input int s,
                                input int ah, input int am, input bit adj,
                                input logic [3:0] led, input bit alm);
        exp_t e;
        e.name = n;
        e.v    = {5'(h), 6'(m), 6'(s), 5'(ah), 6'(am), adj, led, alm};
        return e;
    endfunction

    function automatic string fmt(input logic [33:0] v);
        return $sformatf("%0d:%0d:%0d alm %0d:%0d adj=%b led=%b alarm=%b",
                         v[33:29], v[28:23], v[22:17], v[16:12], v[11:6],
                         v[5], v[4:1], v[0]);
    endfunction

    // Drives one cycle of inputs; called and returns at posedge+1.
    task automatic pulse(input logic en, input logic c, input logic u,
                         input logic d, input logic l, input logic r);
        bus.en_1hz = en; bus.btn_c = c; bus.btn_u = u;
        bus.btn_d = d;   bus.btn_l = l; bus.btn_r = r;
        @(posedge clk);
        #1;
        bus.en_1hz = 0; bus.btn_c = 0; bus.btn_u = 0;
        bus.btn_d = 0;  bus.btn_l = 0; bus.btn_r = 0;
    endtask

    task automatic rep(input int n, input logic en, input logic c, input logic u,
                       input logic d, input logic l, input logic r);
        for (int i = 0; i < n; i++) pulse(en, c, u, d, l, r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        @(posedge clk);
        #3;
        sb.push_back(mk("reset_async", 0, 0, 0, 0, 0, 0, 4'b0000, 0));
        rst = 1'b1;
        #1;
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back(mk("reset_idle", 0, 0, 0, 0, 0, 0, 4'b0000, 0));
        rep(2, 0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
    endtask

    task automatic test_reset_midcount();
        exp_t e;
        do_reset();
        sb.push_back(mk("midcount_time", 12, 34, 56, 0, 0, 0, 4'b0000, 0));
        pulse(0, 1, 0, 0, 0, 0);
        rep(12, 0, 0, 1, 0, 0, 0);
        pulse(0, 0, 0, 0, 0, 1);
        rep(34, 0, 0, 1, 0, 0, 0);
        pulse(0, 1, 0, 0, 0, 0);
        rep(56, 1, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("midcount_async_rst", 0, 0, 0, 0, 0, 0, 4'b0000, 0));
        #3;
        rst = 1'b1;
        #1;
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back(mk("sel_after_rst", 0, 0, 0, 0, 0, 1, 4'b0001, 0));
        pulse(0, 1, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
    endtask

    task automatic test_rollover();
        exp_t e;
        do_reset();
        sb.push_back(mk("pre_midnight", 23, 59, 59, 0, 0, 0, 4'b0000, 0));
        pulse(0, 1, 0, 0, 0, 0);
        pulse(0, 0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 0, 1);
        pulse(0, 0, 0, 1, 0, 0);
        pulse(0, 1, 0, 0, 0, 0);
        rep(59, 1, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        // Alarm is 00:00 after reset, so midnight also fires it.
        sb.push_back(mk("midnight_wrap", 0, 0, 0, 0, 0, 0, 4'b0000, 1));
        pulse(1, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("clear_consumes_c", 0, 0, 0, 0, 0, 0, 4'b0000, 0));
        pulse(0, 1, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        do_reset();
        sb.push_back(mk("pre_11", 10, 59, 59, 0, 0, 0, 4'b0000, 0));
        pulse(0, 1, 0, 0, 0, 0);
        rep(10, 0, 0, 1, 0, 0, 0);
        pulse(0, 0, 0, 0, 0, 1);
        pulse(0, 0, 0, 1, 0, 0);
        pulse(0, 1, 0, 0, 0, 0);
        rep(59, 1, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("hour_carry", 11, 0, 0, 0, 0, 0, 4'b0000, 0));
        pulse(1, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
    endtask

    task automatic test_adjust_wrap();
        exp_t e;
        exp_t steps[$];
        do_reset();
        // Each entry pairs with one stimulus step below, in order.
        steps.push_back(mk("adj_entry",         0,  0, 0,  0,  0, 1, 4'b0001, 0));
        steps.push_back(mk("hr_dn_wrap",        23, 0, 0,  0,  0, 1, 4'b0001, 0));
        steps.push_back(mk("sel_r",             23, 0, 0,  0,  0, 1, 4'b0010, 0));
        steps.push_back(mk("min_59",            23, 59, 0, 0,  0, 1, 4'b0010, 0));
        steps.push_back(mk("min_wrap_no_carry", 23, 0, 0,  0,  0, 1, 4'b0010, 0));
        steps.push_back(mk("sel_l",             23, 0, 0,  0,  0, 1, 4'b0001, 0));
        steps.push_back(mk("sel_l_wrap",        23, 0, 0,  0,  0, 1, 4'b1000, 0));
        steps.push_back(mk("am_dn_wrap",        23, 0, 0,  0, 59, 1, 4'b1000, 0));
        steps.push_back(mk("ah_dn_wrap",        23, 0, 0, 23, 59, 1, 4'b0100, 0));
        steps.push_back(mk("sel_r_wrap",        23, 0, 0, 23, 59, 1, 4'b0001, 0));
        steps.push_back(mk("hr_up_wrap",        0,  0, 0, 23, 59, 1, 4'b0001, 0));
        for (int k = 0; k < 11; k++) begin
            sb.push_back(steps.pop_front());
            case (k)
                0: pulse(0, 1, 0, 0, 0, 0);
                1: pulse(0, 0, 0, 1, 0, 0);
                2: pulse(0, 0, 0, 0, 0, 1);
                3: rep(59, 0, 0, 1, 0, 0, 0);
                4: pulse(0, 0, 1, 0, 0, 0);
                5: pulse(0, 0, 0, 0, 1, 0);
                6: pulse(0, 0, 0, 0, 1, 0);
                7: pulse(0, 0, 0, 1, 0, 0);
                8: begin pulse(0, 0, 0, 0, 1, 0); pulse(0, 0, 0, 1, 0, 0); end
                9: rep(2, 0, 0, 0, 0, 0, 1);
                default: pulse(0, 0, 1, 0, 0, 0);
            endcase
            e = sb.pop_front(); n_checks++;
            if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        exp_t e;
        do_reset();
        pulse(0, 1, 0, 0, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        sb.push_back(mk("c_over_u", 1, 0, 0, 0, 0, 0, 4'b0000, 0));
        pulse(0, 1, 1, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        pulse(0, 1, 0, 0, 0, 0);
        sb.push_back(mk("u_and_d", 1, 0, 0, 0, 0, 1, 4'b0001, 0));
        pulse(0, 0, 1, 1, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("en_in_adjust", 1, 0, 0, 0, 0, 1, 4'b0001, 0));
        rep(3, 1, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("l_and_r", 1, 0, 0, 0, 0, 1, 4'b0001, 0));
        pulse(0, 0, 0, 0, 1, 1);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("u_over_r", 2, 0, 0, 0, 0, 1, 4'b0001, 0));
        pulse(0, 0, 1, 0, 0, 1);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        pulse(0, 1, 0, 0, 0, 0);
        sb.push_back(mk("clock_ignores_btns", 2, 0, 0, 0, 0, 0, 4'b0000, 0));
        pulse(0, 0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 0, 1);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("sel_kept", 2, 0, 0, 0, 0, 1, 4'b0001, 0));
        pulse(0, 1, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        pulse(0, 0, 0, 0, 0, 1);
        pulse(0, 1, 0, 0, 0, 0);
        sb.push_back(mk("sel_retained", 2, 0, 0, 0, 0, 1, 4'b0010, 0));
        pulse(0, 1, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
    endtask

    task automatic test_alarm();
        exp_t e;
        do_reset();
        pulse(0, 1, 0, 0, 0, 0);
        rep(2, 0, 0, 0, 0, 0, 1);
        rep(7, 0, 0, 1, 0, 0, 0);
        pulse(0, 0, 0, 0, 0, 1);
        rep(30, 0, 0, 1, 0, 0, 0);
        pulse(0, 0, 0, 0, 0, 1);
        rep(7, 0, 0, 1, 0, 0, 0);
        pulse(0, 0, 0, 0, 0, 1);
        rep(29, 0, 0, 1, 0, 0, 0);
        pulse(0, 1, 0, 0, 0, 0);
        sb.push_back(mk("pre_match", 7, 29, 59, 7, 30, 0, 4'b0000, 0));
        rep(59, 1, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("alarm_set", 7, 30, 0, 7, 30, 0, 4'b0000, 1));
        pulse(1, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("alarm_latched", 7, 30, 1, 7, 30, 0, 4'b0000, 1));
        pulse(1, 0, 0, 0, 0, 0);
        rep(3, 0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("clear_consumes_u", 7, 30, 1, 7, 30, 0, 4'b0000, 0));
        pulse(0, 0, 1, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("adjust_entry_clr_s", 7, 30, 0, 7, 30, 1, 4'b0010, 0));
        pulse(0, 1, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        pulse(0, 0, 0, 1, 0, 0);
        sb.push_back(mk("edit_onto_alarm", 7, 30, 0, 7, 30, 1, 4'b0010, 0));
        pulse(0, 0, 1, 0, 0, 0);
        pulse(1, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
        sb.push_back(mk("resume_from_0", 7, 30, 1, 7, 30, 0, 4'b0000, 0));
        pulse(0, 1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.v) $display("FAIL %s: got %s, want %s", e.name, fmt(obs()), fmt(e.v));
        else n_pass++;
    endtask

    initial begin
        bus.en_1hz = 0; bus.btn_c = 0; bus.btn_u = 0;
        bus.btn_d = 0;  bus.btn_l = 0; bus.btn_r = 0;
        test_reset();
        test_reset_midcount();
        test_rollover();
        test_adjust_wrap();
        test_priority();
        test_alarm();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Consumes the one-cycle button ticks produced by the push-button detect stages (centre, up, down, left, right) plus a 1 Hz enable pulse.
- Runs a 24-hour time-of-day counter and a stored alarm time.
- Provides a CLOCK/ADJUST mode state machine for setting both values.
- Raises a latched alarm flag on a time match.
- Sits between the button conditioning stages and the display/buzzer drivers.

Parameters:
- H_MOD, 24, hours modulus (hours count 0..H_MOD-1)
- M_MOD, 60, minutes and seconds modulus (0..M_MOD-1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en_1hz  in  1  one-clk-wide pulse at 1 Hz, clk domain
- btn_c  in  1  centre tick, one clk wide; toggles mode
- btn_u  in  1  up tick; increments the selected field
- btn_d  in  1  down tick; decrements the selected field
- btn_l  in  1  left tick; selects the previous field
- btn_r  in  1  right tick; selects the next field
- hours  out  5  clock hours, binary 0..23
- minutes  out  6  clock minutes, binary 0..59
- seconds  out  6  clock seconds, binary 0..59
- alm_hours  out  5  alarm hours
- alm_minutes  out  6  alarm minutes
- adjust_mode  out  1  1 = ADJUST, 0 = CLOCK
- sel_led  out  4  one-hot selected field in ADJUST; 4'b0000 in CLOCK
- alarm  out  1  latched alarm indication

Behaviour:
- Reset (async, rst=1):
  - mode=CLOCK, sel=0.
  - All time and alarm registers=0.
  - alarm=0, sel_led=0.
  - All outputs are registered and take these values immediately.
- Field index order:
  - 0 = clock hours, 1 = clock minutes, 2 = alarm hours, 3 = alarm minutes.
  - sel_led[i]=1 when sel==i and mode==ADJUST.
- Per-cycle input priority: alarm-clear > btn_c > (btn_u/btn_d) > (btn_l/btn_r). Only the highest-priority event present acts; lower ones in the same cycle are dropped.
- Alarm clear:
  - If alarm=1, any button tick clears alarm on the next edge.
  - That tick is consumed and has no other effect.
- CLOCK state:
  - On en_1hz: seconds+1.
  - 59->0 carries minutes+1; minutes 59->0 carries hours+1; hours 23->0.
  - btn_c -> ADJUST on the next edge.
  - ADJUST entry clears seconds to 0 and keeps sel at its last value.
  - btn_u/d/l/r are ignored in CLOCK.
- ADJUST state:
  - en_1hz is ignored; time is frozen.
  - btn_c -> CLOCK; seconds resume from 0 on the next en_1hz.
  - btn_r: sel=(sel+1) mod 4, so 3->0. btn_l: sel=(sel-1) mod 4, so 0->3.
  - btn_l and btn_r in the same cycle: no change.
  - btn_u: selected field +1, wraps at modulus (23->0, 59->0).
  - btn_d: selected field -1, wraps (0->23, 0->59).
  - btn_u and btn_d in the same cycle: no change.
  - Adjusting never carries into the neighbouring field.
- Alarm set:
  - Asserted in CLOCK only, on an en_1hz cycle whose post-update time is hours==alm_hours, minutes==alm_minutes, seconds==0.
  - Latches; it is not retriggered while already 1.
  - Never set in ADJUST. Editing time onto the alarm value does not fire it.
- Latency:
  - Every tick takes effect on the clk edge where it is sampled.
  - Outputs update 1 cycle after the tick.
- Reset mid-operation: any state returns to reset values asynchronously. No pending events survive.
- Arithmetic: compare-then-load at the modulus boundary. No out-of-range value is ever reachable or output.

Decomposition:
- Shared package:
  - Mode encoding: MODE_CLOCK=1'b0, MODE_ADJUST=1'b1.
  - Field index constants: F_CLK_H=0, F_CLK_M=1, F_ALM_H=2, F_ALM_M=3.
  - Width constants: H_W=5, M_W=6.
- Sub-module wrap_counter #(MOD, W):
  - Ports: inc, dec, clr, load-free.
  - Outputs: value and carry (carry high when inc wraps MOD-1->0).
  - Instantiated for seconds, minutes, hours, alarm hours and alarm minutes.
  - The top level holds the mode FSM, sel register, priority logic and alarm latch.

Test Plan:
- Reset mid-count: rst pulse at time 12:34:56 -> all outputs 0 within the same cycle, adjust_mode=0, sel_led=0000.
- Rollover: in CLOCK, load 23:59:59 via ADJUST then drive en_1hz -> time reads 00:00:00. Also 10:59:59 -> 11:00:00.
- Adjust wrap:
  - btn_c, then btn_d on sel=0 from hours=0 -> hours=23, sel_led=0001.
  - btn_r, btn_u ×60 -> minutes returns to its start value; hours unchanged.
  - btn_l at sel=0 -> sel_led=1000.
- Priority/simultaneous:
  - btn_c+btn_u same cycle in ADJUST -> mode CLOCK, field unchanged.
  - btn_u+btn_d -> no change.
  - en_1hz during ADJUST -> seconds stay 0.
- Alarm:
  - Set alarm 07:30, time 07:29:59 in CLOCK, en_1hz -> alarm=1 the next cycle.
  - btn_u -> alarm=0 and minutes unchanged (consumed).
  - Setting time to 07:30 in ADJUST -> alarm stays 0.
